// File: rtl/api_slave.sv
// Chip-side responder for the hash-board serial API: shifts work in on mosi, report out on miso.
// Define API_SLAVE_TIMEOUT_EN to abort a load window after TIMEOUT idle clk cycles.
module api_slave #(
   parameter int WORK_WORDS = 23,
   parameter int REP_WORDS  = 4,
   parameter int RES_DEPTH  = 4,
   parameter int TIMEOUT    = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sck,
   input  logic                     mosi,
   input  logic                     load,
   output logic                     miso,
   output logic                     work_vld,
   output logic [WORK_WORDS*32-1:0] work_dat,
   input  logic                     res_vld,
   input  logic [31:0]              res_dat,
   output logic                     res_rdy,
   output logic [15:0]              frame_cnt,
   output logic [7:0]               err_cnt
);

   localparam int SR_W = WORK_WORDS*32;
   localparam int PTR_W = $clog2(RES_DEPTH);
   localparam int CW = PTR_W + 1;
   localparam int POP_MAX = REP_WORDS - 1;
   localparam logic [31:0] POP_MAX_L = 32'(POP_MAX);

   if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0 ||
       TIMEOUT < 1 || TIMEOUT > 8191 || REP_WORDS >= WORK_WORDS) begin : g_bad_param
      $error("api_slave: unsupported parameter set");
   end

   logic [1:0] sck_sync, mosi_sync, load_sync;
   logic       sck_s, mosi_s, load_s;
   logic       sck_d, load_d;
   logic       sck_rise, sck_fall, load_rise, load_fall, selected;

   logic [SR_W-1:0]  sr;
   logic [SR_W-1:0]  rep_sr;
   logic [4:0]       bit_cnt;
   logic [7:0]       word_cnt;
   logic             frame_ok;
   logic [15:0]      frame_nxt;

   logic [31:0]      mem [RES_DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0]    fifo_cnt;
   logic             push;
   logic [7:0]       pop_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= 2'b00;
         mosi_sync <= 2'b00;
         load_sync <= 2'b11;
         sck_d     <= 1'b0;
         load_d    <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[0], sck};
         mosi_sync <= {mosi_sync[0], mosi};
         load_sync <= {load_sync[0], load};
         sck_d     <= sck_s;
         load_d    <= load_s;
      end
   end

   assign sck_s     = sck_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign load_s    = load_sync[1];
   assign sck_rise  = sck_s & ~sck_d;
   assign sck_fall  = ~sck_s & sck_d;
   assign load_rise = load_s & ~load_d;
   assign load_fall = ~load_s & load_d;
   assign selected  = ~load_s;

   assign frame_ok  = (word_cnt == 8'(WORK_WORDS)) && (bit_cnt == 5'd0);
   assign frame_nxt = frame_ok ? frame_cnt + 16'd1 : frame_cnt;

   // nonce FIFO; pops only happen in the report-load cycle
   assign res_rdy = (fifo_cnt != CW'(RES_DEPTH));
   assign push    = res_vld & res_rdy;

   always_comb begin
      pop_n = 8'd0;
      if (load_rise) begin
         if (32'(fifo_cnt) > POP_MAX_L) pop_n = POP_MAX_L[7:0];
         else                           pop_n = 8'(fifo_cnt);
      end
   end

   always_comb begin
      rep_sr = '0;
      rep_sr[SR_W-1 -: 32] = {8'hA5, pop_n, frame_nxt};
      for (int i = 0; i < POP_MAX; i++) begin
         if (8'(i) < pop_n) rep_sr[SR_W-1-32*(i+1) -: 32] = mem[rd_ptr + PTR_W'(i)];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= res_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr   <= rd_ptr + PTR_W'(pop_n);
         fifo_cnt <= fifo_cnt - CW'(pop_n) + CW'(push);
      end
   end

`ifdef API_SLAVE_TIMEOUT_EN
   logic [12:0]             to_cnt;
   logic                    to_hit;
   logic [REP_WORDS*32-1:0] rep_snap;

   always_ff @(posedge clk) begin
      if (rst || !selected || sck_rise || sck_fall) to_cnt <= 13'd0;
      else if (to_cnt != 13'(TIMEOUT))              to_cnt <= to_cnt + 13'd1;
   end

   assign to_hit = selected && !load_fall && !sck_rise && !sck_fall &&
                   (to_cnt == 13'(TIMEOUT - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         miso      <= 1'b1;
         bit_cnt   <= 5'd0;
         word_cnt  <= 8'd0;
         work_vld  <= 1'b0;
         work_dat  <= '0;
         frame_cnt <= 16'd0;
         err_cnt   <= 8'd0;
`ifdef API_SLAVE_TIMEOUT_EN
         rep_snap  <= '0;
`endif
      end else begin
         work_vld <= 1'b0;
         if (load_rise) begin
            // the old sr is the received frame; the report replaces it in the same cycle
            sr   <= rep_sr;
            miso <= 1'b1;
`ifdef API_SLAVE_TIMEOUT_EN
            rep_snap <= rep_sr[SR_W-1 -: REP_WORDS*32];
`endif
            if (frame_ok) begin
               work_dat  <= sr;
               work_vld  <= 1'b1;
               frame_cnt <= frame_nxt;
            end else if (err_cnt != 8'hFF) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end else if (!selected) begin
            miso <= 1'b1;
         end else if (load_fall) begin
            bit_cnt  <= 5'd0;
            word_cnt <= 8'd0;
            miso     <= sr[SR_W-1];
         end
`ifdef API_SLAVE_TIMEOUT_EN
         else if (to_hit) begin
            bit_cnt  <= 5'd0;
            word_cnt <= 8'd0;
            miso     <= 1'b1;
            sr       <= {rep_snap, {(SR_W-REP_WORDS*32){1'b0}}};
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
`endif
         else begin
            if (sck_rise) begin
               sr      <= {sr[SR_W-2:0], mosi_s};
               bit_cnt <= bit_cnt + 5'd1;
               if (bit_cnt == 5'd31 && word_cnt != 8'(WORK_WORDS + 1))
                  word_cnt <= word_cnt + 8'd1;
            end
            if (sck_fall) miso <= sr[SR_W-1];
         end
      end
   end

endmodule

// File: tb/tb_api_slave.sv
// Directed bench for api_slave: a frame-level model of report contents, FIFO and counters.
module tb_api_slave;
   localparam int WW = 23;
   localparam int RW = 4;
   localparam int RD = 4;
   localparam int H  = 4;
`ifdef API_SLAVE_TIMEOUT_EN
   localparam int TO = 64;
`else
   localparam int TO = 4096;
`endif

   logic             clk = 1'b0;
   logic             rst, sck, mosi, load;
   logic             miso, work_vld;
   logic [WW*32-1:0] work_dat;
   logic             res_vld;
   logic [31:0]      res_dat;
   logic             res_rdy;
   logic [15:0]      frame_cnt;
   logic [7:0]       err_cnt;

   api_slave #(.WORK_WORDS(WW), .REP_WORDS(RW), .RES_DEPTH(RD), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .load(load), .miso(miso),
      .work_vld(work_vld), .work_dat(work_dat), .res_vld(res_vld), .res_dat(res_dat),
      .res_rdy(res_rdy), .frame_cnt(frame_cnt), .err_cnt(err_cnt));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [31:0]      m_rep [WW];
   logic [31:0]      m_q [$];
   logic [15:0]      m_frame;
   logic [7:0]       m_err;
   logic [WW*32-1:0] exp_q [$];
   logic [31:0]      cap [WW];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_frame = 16'd0;
      m_err = 8'd0;
      for (int i = 0; i < WW; i++) m_rep[i] = 32'd0;
   endtask

   task automatic model_end_frame(input int nbits);
      int n;
      if (nbits == WW*32) m_frame = m_frame + 16'd1;
      else if (m_err != 8'hFF) m_err = m_err + 8'd1;
      n = (m_q.size() < RW-1) ? m_q.size() : RW-1;
      for (int i = 0; i < WW; i++) m_rep[i] = 32'd0;
      m_rep[0] = {8'hA5, 8'(n), m_frame};
      for (int i = 0; i < n; i++) m_rep[i+1] = m_q.pop_front();
   endtask

   // single compare process: commits against the expected queue, idle-state outputs against the model
   always @(negedge clk) begin
      logic [WW*32-1:0] e;
      if (work_vld) begin
         if (exp_q.size() == 0) chk("work_vld_unexpected", 32'(work_vld), 32'd0);
         else begin
            e = exp_q.pop_front();
            for (int w = 0; w < WW; w++)
               chk($sformatf("work_dat_w%0d", w), work_dat[WW*32-1-32*w -: 32], e[WW*32-1-32*w -: 32]);
         end
      end
      if (chk_en) begin
         chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
         chk("err_cnt", 32'(err_cnt), 32'(m_err));
         chk("res_rdy", 32'(res_rdy), 32'(m_q.size() < RD));
         chk("miso_idle", 32'(miso), 32'd1);
      end
   end

   task automatic do_reset();
      chk_en = 1'b0;
      rst = 1'b1; sck = 1'b0; mosi = 1'b0; res_vld = 1'b0; res_dat = 32'd0;
      cyc(3);
      load = 1'b1;
      cyc(5);
      chk("rst_miso", 32'(miso), 32'd1);
      chk("rst_work_vld", 32'(work_vld), 32'd0);
      chk("rst_work_dat", 32'(|work_dat), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_res_rdy", 32'(res_rdy), 32'd1);
      rst = 1'b0;
      model_reset();
      cyc(2);
      chk_en = 1'b1;
   endtask

   task automatic push(input logic [31:0] d);
      bit acc;
      acc = (m_q.size() < RD);
      chk("res_rdy_pre", 32'(res_rdy), 32'(acc));
      res_vld = 1'b1; res_dat = d;
      @(posedge clk); #1;
      res_vld = 1'b0;
      if (acc) m_q.push_back(d);
   endtask

   task automatic run_frame(input int nwords, input logic [31:0] base, input bit close);
      logic [WW*32-1:0] sent;
      logic [31:0] w, c;
      chk_en = 1'b0;
      sent = '0;
      load = 1'b0;
      for (int wi = 0; wi < nwords; wi++) begin
         w = base + 32'(wi);
         sent = {sent[WW*32-33:0], w};
         c = 32'd0;
         for (int b = 31; b >= 0; b--) begin
            mosi = w[b];
            cyc(H);
            c = {c[30:0], miso};
            sck = 1'b1;
            cyc(H);
            sck = 1'b0;
         end
         if (wi < WW) begin
            cap[wi] = c;
            chk($sformatf("miso_w%0d", wi), c, m_rep[wi]);
         end
      end
      if (close) begin
         cyc(H);
         if (nwords == WW) exp_q.push_back(sent);
         load = 1'b1;
         cyc(8);
         chk("commit_seen", 32'(exp_q.size()), 32'd0);
         model_end_frame(nwords*32);
         chk_en = 1'b1;
         cyc(2);
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b1; sck = 1'b0; mosi = 1'b0; res_vld = 1'b0; res_dat = 32'd0;
      do_reset();

      // single full frame
      run_frame(WW, 32'h1, 1'b1);
      chk("t1_word0", work_dat[WW*32-1 -: 32], 32'h0000_0001);
      chk("t1_word22", work_dat[31:0], 32'h0000_0017);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_err_cnt", 32'(err_cnt), 32'd0);

      // two nonces surface in the following frame's report
      do_reset();
      push(32'h11);
      push(32'h22);
      run_frame(WW, 32'h100, 1'b1);
      run_frame(WW, 32'h200, 1'b1);
      chk("t2_rep0", cap[0], 32'hA502_0001);
      chk("t2_rep1", cap[1], 32'h0000_0011);
      chk("t2_rep2", cap[2], 32'h0000_0022);
      chk("t2_rep3", cap[3], 32'h0000_0000);
      begin
         logic [31:0] acc;
         acc = 32'd0;
         for (int i = 4; i < WW; i++) acc = acc | cap[i];
         chk("t2_tail_zero", acc, 32'd0);
      end

      // FIFO fills at four; the fifth push is refused
      for (int i = 0; i < 5; i++) begin
         if (i == 4) chk("t3_rdy_full", 32'(res_rdy), 32'd0);
         push(32'h31 + 32'(i));
      end
      run_frame(WW, 32'h300, 1'b1);
      chk("t3_rdy_after", 32'(res_rdy), 32'd1);
      chk("t3_model_left", 32'(m_q.size()), 32'd1);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);

      // short frame: report still shifts out, no commit
      run_frame(WW-1, 32'h400, 1'b1);
      chk("t4_rep0", cap[0], 32'hA503_0003);
      chk("t4_rep1", cap[1], 32'h0000_0031);
      chk("t4_rep3", cap[3], 32'h0000_0033);
      chk("t4_err_cnt", 32'(err_cnt), 32'd1);
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);

      // reset mid-frame, then a clean frame
      run_frame(10, 32'h500, 1'b0);
      do_reset();
      run_frame(WW, 32'h600, 1'b1);
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t5_word0", work_dat[WW*32-1 -: 32], 32'h0000_0600);
      chk("t5_err_cnt", 32'(err_cnt), 32'd0);

`ifdef API_SLAVE_TIMEOUT_EN
      // sck stalls inside the window long enough to abort
      run_frame(2, 32'h700, 1'b0);
      cyc(100);
      chk("to_miso", 32'(miso), 32'd1);
      chk("to_err_cnt", 32'(err_cnt), 32'd1);
      load = 1'b1;
      cyc(8);
      m_err = m_err + 8'd1;
      model_end_frame(0);
      chk("to_err_after_rise", 32'(err_cnt), 32'd2);
      chk("to_frame_cnt", 32'(frame_cnt), 32'd1);
      chk_en = 1'b1;
      cyc(2);
`endif

      cyc(5);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
